// File: rtl/tm1638_pkg.sv
// Shared TM1638 bus definitions: command bytes, key-scan type and LED&KEY button decode.
package tm1638_pkg;

  typedef logic [31:0] key_scan_t;

  localparam logic [7:0] DATA_CMD      = 8'h40;
  // Bit 1 selects key read; bit 2 left clear keeps auto address increment.
  localparam logic [7:0] DATA_READ_DIR = 8'h02;
  localparam logic [7:0] READ_KEYS_CMD = DATA_CMD | DATA_READ_DIR;

  localparam int KEY_SCAN_BYTES = 4;
  localparam int KEY_SCAN_BITS  = KEY_SCAN_BYTES * 8;

  // LED&KEY boards wire S1..S8 to bits 0 and 4 of each scan byte.
  function automatic logic [7:0] decode_buttons(input key_scan_t k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < KEY_SCAN_BYTES; i++) begin
      b[2*i]   = k[8*i];
      b[2*i+1] = k[8*i+4];
    end
    return b;
  endfunction

endpackage

// File: rtl/tm1638_bit_timer.sv
// Serial clock generator: per bit a CLK_DIV-cycle low phase then a CLK_DIV-cycle high phase.
// Strobes are combinational and describe the current cycle; sclk idles high when no bits remain.
module tm1638_bit_timer #(
  parameter int CLK_DIV = 50
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [5:0] i_bits,
  output logic       o_sclk,
  output logic       o_rise,
  output logic       o_fall,
  output logic       o_sample,
  output logic       o_last
);

  localparam int HW = $clog2(CLK_DIV);

  logic [HW-1:0] r_hcnt;
  logic          r_high;
  logic          r_active;
  logic          r_sclk;
  logic [5:0]    r_bits;
  logic          w_half_end;

  assign w_half_end = (r_hcnt == HW'(CLK_DIV - 1));
  assign o_rise     = r_active & ~r_high & w_half_end;
  assign o_sample   = r_active &  r_high & w_half_end;
  assign o_last     = o_sample & (r_bits == 6'd1);
  assign o_fall     = o_sample & ~o_last;
  assign o_sclk     = r_sclk;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hcnt   <= '0;
      r_high   <= 1'b0;
      r_active <= 1'b0;
      r_sclk   <= 1'b1;
      r_bits   <= '0;
    end else if (i_load) begin
      r_hcnt   <= '0;
      r_high   <= 1'b0;
      r_active <= 1'b1;
      r_sclk   <= 1'b0;
      r_bits   <= i_bits;
    end else if (r_active) begin
      if (w_half_end) begin
        r_hcnt <= '0;
        if (!r_high) begin
          r_high <= 1'b1;
          r_sclk <= 1'b1;
        end else if (r_bits == 6'd1) begin
          // Last bit: leave sclk high for whatever phase follows.
          r_high   <= 1'b0;
          r_active <= 1'b0;
        end else begin
          r_bits <= r_bits - 6'd1;
          r_high <= 1'b0;
          r_sclk <= 1'b0;
        end
      end else begin
        r_hcnt <= r_hcnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/tm1638_key_reader.sv
// Reads the four TM1638 key-scan bytes after a read command; done pulses 82*CLK_DIV+WAIT_CYCLES+1 cycles after start.
// start is only honoured in IDLE; the caller guarantees the shared STB/CLK/DIO bus is free.
module tm1638_key_reader
  import tm1638_pkg::*;
#(
  parameter int CLK_DIV     = 50,
  parameter int WAIT_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] keys,
  output logic [7:0]  buttons,
  output logic        stb,
  output logic        sclk,
  output logic        dio_o,
  output logic        dio_oe,
  input  logic        dio_i
);

  localparam int CNT_MAX = (WAIT_CYCLES > CLK_DIV) ? WAIT_CYCLES : CLK_DIV;
  localparam int CNT_W   = $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STB_SETUP,
    S_CMD,
    S_WAIT,
    S_READ,
    S_STB_HOLD,
    S_DONE
  } state_t;

  state_t           r_state, w_state;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic [7:0]       r_cmd, w_cmd;
  logic             r_stb, w_stb;
  logic             r_dio_o, w_dio_o;
  logic             r_dio_oe, w_dio_oe;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             w_load_keys;
  logic             w_tmr_load;
  logic [5:0]       w_tmr_bits;
  key_scan_t        r_keys;
  logic [7:0]       r_buttons;
  key_scan_t        r_shift;
  logic [1:0]       r_sync;

  logic w_sclk, w_rise, w_fall, w_sample, w_last;

  tm1638_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_bit_timer (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_load   (w_tmr_load),
    .i_bits   (w_tmr_bits),
    .o_sclk   (w_sclk),
    .o_rise   (w_rise),
    .o_fall   (w_fall),
    .o_sample (w_sample),
    .o_last   (w_last)
  );

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_cmd       = r_cmd;
    w_stb       = r_stb;
    w_dio_o     = r_dio_o;
    w_dio_oe    = r_dio_oe;
    w_busy      = r_busy;
    w_done      = 1'b0;
    w_load_keys = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_bits  = 6'd0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state  = S_STB_SETUP;
          w_stb    = 1'b0;
          w_dio_oe = 1'b1;
          w_dio_o  = READ_KEYS_CMD[0];
          w_cmd    = READ_KEYS_CMD;
          w_cnt    = CNT_W'(CLK_DIV - 1);
          w_busy   = 1'b1;
        end
      end
      S_STB_SETUP: begin
        if (r_cnt == '0) begin
          w_state    = S_CMD;
          w_tmr_load = 1'b1;
          w_tmr_bits = 6'd8;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_CMD: begin
        // Drop the bit once the chip has latched it; present the next at the fall.
        if (w_rise) w_cmd = r_cmd >> 1;
        if (w_fall) w_dio_o = r_cmd[0];
        if (w_last) begin
          w_state  = S_WAIT;
          w_dio_oe = 1'b0;
          w_dio_o  = 1'b1;
          w_cnt    = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state    = S_READ;
          w_tmr_load = 1'b1;
          w_tmr_bits = 6'(KEY_SCAN_BITS);
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_READ: begin
        if (w_last) begin
          w_state = S_STB_HOLD;
          w_stb   = 1'b1;
          w_cnt   = CNT_W'(CLK_DIV - 1);
        end
      end
      S_STB_HOLD: begin
        if (r_cnt == '0) begin
          w_state     = S_DONE;
          w_done      = 1'b1;
          w_load_keys = 1'b1;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_stb     <= 1'b1;
      r_dio_o   <= 1'b1;
      r_dio_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_keys    <= '0;
      r_buttons <= '0;
      r_shift   <= '0;
      r_sync    <= 2'b11;
    end else begin
      r_state  <= w_state;
      r_cnt    <= w_cnt;
      r_cmd    <= w_cmd;
      r_stb    <= w_stb;
      r_dio_o  <= w_dio_o;
      r_dio_oe <= w_dio_oe;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_sync   <= {r_sync[0], dio_i};
      // Bits arrive LSB first, so shift in from the top.
      if (r_state == S_READ && w_sample) r_shift <= {r_sync[1], r_shift[31:1]};
      if (w_load_keys) begin
        r_keys    <= r_shift;
        r_buttons <= decode_buttons(r_shift);
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign keys    = r_keys;
  assign buttons = r_buttons;
  assign stb     = r_stb;
  assign sclk    = w_sclk;
  assign dio_o   = r_dio_o;
  assign dio_oe  = r_dio_oe;

endmodule

// File: tb/tb_tm1638_key_reader.sv
// Directed bench for tm1638_key_reader with a TM1638 key-scan responder on DIO.
module tb_tm1638_key_reader;

  localparam int CD = 4;
  localparam int WC = 8;
  localparam int DONE_CYC = 82 * CD + WC + 1;   // 337
  localparam int HOLD_START = DONE_CYC - CD;    // first STB_HOLD cycle, 333

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        dio_i = 1'b1;
  logic        busy, done, stb, sclk, dio_o, dio_oe;
  logic [31:0] keys;
  logic [7:0]  buttons;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] resp_bits = 32'h0;
  int          ridx = 0;
  logic        resp_prev_sclk = 1'b1;

  always #5 clk = ~clk;

  tm1638_key_reader #(
    .CLK_DIV     (CD),
    .WAIT_CYCLES (WC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .keys    (keys),
    .buttons (buttons),
    .stb     (stb),
    .sclk    (sclk),
    .dio_o   (dio_o),
    .dio_oe  (dio_oe),
    .dio_i   (dio_i)
  );

  // TM1638 model: after each CLK fall while reading, present the next scan bit.
  always @(posedge clk) begin
    #1;
    if (stb) ridx = 0;
    else if (resp_prev_sclk && !sclk && !dio_oe && ridx < 32) begin
      dio_i = resp_bits[ridx];
      ridx++;
    end
    resp_prev_sclk = sclk;
  end

  task automatic run_txn(input logic [31:0] rb, input bit hold,
                         output int done_cyc, output int done_cnt, output int rises,
                         output logic [7:0] cmd_bits, output int oe_cnt, output int oe_last,
                         output int stb_bad, output int stb_falls);
    logic prev_sclk = 1'b1;
    logic prev_stb = 1'b1;
    int   cyc;
    resp_bits = rb;
    done_cyc = -1; done_cnt = 0; rises = 0; cmd_bits = 8'h00;
    oe_cnt = 0; oe_last = -1; stb_bad = 0; stb_falls = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cyc = 1;
    while (cyc < 1200 && !(done_cnt > 0 && cyc > done_cyc + 2)) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        start = 1'b0;
      end
      if (!prev_sclk && sclk) begin
        rises++;
        if (stb) stb_bad++;
        if (rises <= 8) cmd_bits[rises-1] = dio_o;
      end
      if (stb && cyc < HOLD_START) stb_bad++;
      if (dio_oe) begin oe_cnt++; oe_last = cyc; end
      if (prev_stb && !stb) stb_falls++;
      prev_sclk = sclk;
      prev_stb  = stb;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (stb !== 1'b1)     begin miscompares++; $display("FAIL reset_stb: got %b want 1", stb); end
    vectors++; if (sclk !== 1'b1)    begin miscompares++; $display("FAIL reset_sclk: got %b want 1", sclk); end
    vectors++; if (dio_oe !== 1'b0)  begin miscompares++; $display("FAIL reset_dio_oe: got %b want 0", dio_oe); end
    vectors++; if (dio_o !== 1'b1)   begin miscompares++; $display("FAIL reset_dio_o: got %b want 1", dio_o); end
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (keys !== 32'h0)   begin miscompares++; $display("FAIL reset_keys: got %h want 0", keys); end
    vectors++; if (buttons !== 8'h0) begin miscompares++; $display("FAIL reset_buttons: got %h want 0", buttons); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_command_bits();
    int dc, dn, ri, oc, ol, sb, sf;
    logic [7:0] cb;
    run_txn(32'h0000_0000, 1'b0, dc, dn, ri, cb, oc, ol, sb, sf);
    vectors++; if (cb !== 8'h42) begin miscompares++; $display("FAIL cmd_bits: got %h want 42", cb); end
    vectors++; if (oc != 68)     begin miscompares++; $display("FAIL cmd_oe_cycles: got %0d want 68", oc); end
    vectors++; if (ol != 68)     begin miscompares++; $display("FAIL cmd_oe_last: got %0d want 68", ol); end
  endtask

  task automatic test_decode();
    int dc, dn, ri, oc, ol, sb, sf;
    logic [7:0] cb;
    run_txn({8'h51, 8'h00, 8'h10, 8'h01}, 1'b0, dc, dn, ri, cb, oc, ol, sb, sf);
    vectors++; if (keys !== 32'h5100_1001) begin miscompares++; $display("FAIL decode_keys: got %h want 51001001", keys); end
    vectors++; if (buttons !== 8'hC9)      begin miscompares++; $display("FAIL decode_buttons: got %h want c9", buttons); end
  endtask

  task automatic test_latency();
    int dc, dn, ri, oc, ol, sb, sf;
    logic [7:0] cb;
    run_txn(32'hA5C3_0F96, 1'b0, dc, dn, ri, cb, oc, ol, sb, sf);
    vectors++; if (dc != DONE_CYC) begin miscompares++; $display("FAIL lat_done_cycle: got %0d want %0d", dc, DONE_CYC); end
    vectors++; if (dn != 1)  begin miscompares++; $display("FAIL lat_done_pulses: got %0d want 1", dn); end
    vectors++; if (ri != 40) begin miscompares++; $display("FAIL lat_sclk_rises: got %0d want 40", ri); end
    vectors++; if (sb != 0)  begin miscompares++; $display("FAIL lat_stb_high: got %0d want 0", sb); end
    vectors++; if (keys !== 32'hA5C3_0F96) begin miscompares++; $display("FAIL lat_keys: got %h want a5c30f96", keys); end
    vectors++; if (buttons !== 8'h56)      begin miscompares++; $display("FAIL lat_buttons: got %h want 56", buttons); end
  endtask

  task automatic test_start_hold();
    int dc, dn, ri, oc, ol, sb, sf;
    logic [7:0] cb;
    run_txn(32'h0000_0001, 1'b1, dc, dn, ri, cb, oc, ol, sb, sf);
    vectors++; if (dn != 1) begin miscompares++; $display("FAIL hold_done_pulses: got %0d want 1", dn); end
    vectors++; if (sf != 1) begin miscompares++; $display("FAIL hold_stb_falls: got %0d want 1", sf); end
    vectors++; if (ri != 40) begin miscompares++; $display("FAIL hold_sclk_rises: got %0d want 40", ri); end
  endtask

  task automatic test_back_to_back();
    int n;
    resp_bits = 32'h0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    vectors++; if (n < 0) begin miscompares++; $display("FAIL b2b_first_done: got timeout want done"); end
    start = 1'b1;  // present during the DONE cycle: ignored
    @(posedge clk); #1;
    vectors++; if (stb !== 1'b1)  begin miscompares++; $display("FAIL b2b_done1_stb: got %b want 1", stb); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_done1_busy: got %b want 0", busy); end
    resp_bits = 32'h1100_0011;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++; if (stb !== 1'b0)  begin miscompares++; $display("FAIL b2b_done2_stb: got %b want 0", stb); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_done2_busy: got %b want 1", busy); end
    wait_done(n);
    vectors++; if (n != DONE_CYC - 1)      begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", n, DONE_CYC - 1); end
    vectors++; if (keys !== 32'h1100_0011) begin miscompares++; $display("FAIL b2b_keys: got %h want 11000011", keys); end
    vectors++; if (buttons !== 8'hC3)      begin miscompares++; $display("FAIL b2b_buttons: got %h want c3", buttons); end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_read();
    int dc, dn, ri, oc, ol, sb, sf;
    logic [7:0] cb;
    resp_bits = 32'h0F0F_0F0F;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (156) @(posedge clk);  // cycle 157: ten read bits complete
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    vectors++; if (stb !== 1'b1)     begin miscompares++; $display("FAIL mid_stb: got %b want 1", stb); end
    vectors++; if (sclk !== 1'b1)    begin miscompares++; $display("FAIL mid_sclk: got %b want 1", sclk); end
    vectors++; if (dio_oe !== 1'b0)  begin miscompares++; $display("FAIL mid_dio_oe: got %b want 0", dio_oe); end
    vectors++; if (dio_o !== 1'b1)   begin miscompares++; $display("FAIL mid_dio_o: got %b want 1", dio_o); end
    vectors++; if (busy !== 1'b0)    begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0)    begin miscompares++; $display("FAIL mid_done: got %b want 0", done); end
    vectors++; if (keys !== 32'h0)   begin miscompares++; $display("FAIL mid_keys: got %h want 0", keys); end
    vectors++; if (buttons !== 8'h0) begin miscompares++; $display("FAIL mid_buttons: got %h want 0", buttons); end
    rst = 1'b0;
    @(posedge clk); #1;
    run_txn(32'hFFFF_FFFF, 1'b0, dc, dn, ri, cb, oc, ol, sb, sf);
    vectors++; if (dc != DONE_CYC)         begin miscompares++; $display("FAIL mid_next_done: got %0d want %0d", dc, DONE_CYC); end
    vectors++; if (keys !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mid_next_keys: got %h want ffffffff", keys); end
    vectors++; if (buttons !== 8'hFF)      begin miscompares++; $display("FAIL mid_next_buttons: got %h want ff", buttons); end
  endtask

  initial begin
    test_reset();
    test_command_bits();
    test_decode();
    test_latency();
    test_start_hold();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
